// File: rtl/ddmtd_nco.sv
// DDMTD loop NCO: clamps the loop-filter word into an FTW and runs the phase accumulator.
// The accumulator MSB becomes the feedback clock; lock is judged from the phase error stream.
module ddmtd_nco #(
  parameter int ACC_W    = 24,
  parameter int CTRL_W   = 24,
  parameter int ERR_W    = 18,
  parameter int CTRL_SH  = 8,
  parameter int FTW_NOM  = 65536,
  parameter int FTW_MIN  = 49152,
  parameter int FTW_MAX  = 81920,
  parameter int LOCK_TOL = 64,
  parameter int LOCK_CNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              ctrl_valid,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              phase_valid,
  input  logic [ERR_W-1:0]  phase_err,
  output logic              clk_fb_out,
  output logic              fb_tick,
  output logic [ACC_W-1:0]  ftw,
  output logic              sat_hi,
  output logic              sat_lo,
  output logic              locked
);

  localparam int SW    = ((ACC_W > CTRL_W) ? ACC_W : CTRL_W) + 2;
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  localparam logic signed [SW-1:0] NOM_S = SW'(FTW_NOM);
  localparam logic signed [SW-1:0] MIN_S = SW'(FTW_MIN);
  localparam logic signed [SW-1:0] MAX_S = SW'(FTW_MAX);

  localparam logic [ACC_W-1:0] NOM_V = ACC_W'(FTW_NOM);
  localparam logic [ACC_W-1:0] MIN_V = ACC_W'(FTW_MIN);
  localparam logic [ACC_W-1:0] MAX_V = ACC_W'(FTW_MAX);
  localparam logic [ERR_W-1:0] TOL_V = ERR_W'(LOCK_TOL);
  localparam logic [CNT_W-1:0] CNT_V = CNT_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MOST_NEG = {1'b1, {(ERR_W-1){1'b0}}};

  localparam logic [1:0] S_UNL = 2'd0;
  localparam logic [1:0] S_ACQ = 2'd1;
  localparam logic [1:0] S_LCK = 2'd2;
  localparam logic [1:0] S_SLP = 2'd3;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_ftw;
  logic             r_clk_fb;
  logic             r_clk_fb_d;
  logic             r_tick;
  logic             r_sat_hi;
  logic             r_sat_lo;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_locked;

  logic signed [SW-1:0] w_ctrl_ext;
  logic signed [SW-1:0] w_delta;
  logic signed [SW-1:0] w_sum;
  logic                 w_over;
  logic                 w_under;
  logic                 w_upd;
  logic                 w_sat;
  logic [ERR_W-1:0]     w_mag;
  logic                 w_good;
  logic [1:0]           w_state_nx;
  logic [CNT_W-1:0]     w_cnt_nx;
  logic [CNT_W-1:0]     w_cnt_inc;

  // Wide signed sum so no control word can wrap past the clamps
  assign w_ctrl_ext = {{(SW-CTRL_W){ctrl[CTRL_W-1]}}, ctrl};
  assign w_delta    = w_ctrl_ext >>> CTRL_SH;
  assign w_sum      = NOM_S + w_delta;
  assign w_over     = w_sum > MAX_S;
  assign w_under    = w_sum < MIN_S;
  assign w_upd      = ctrl_valid & ena;
  assign w_sat      = w_upd & (w_over | w_under);

  // The most negative error has no positive magnitude; always bad
  assign w_mag  = phase_err[ERR_W-1] ? (~phase_err + 1'b1) : phase_err;
  assign w_good = (phase_err != ERR_MOST_NEG) && (w_mag <= TOL_V);

  assign w_cnt_inc = (r_cnt >= CNT_V) ? r_cnt : r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (phase_valid && ena) begin
      unique case (r_state)
        S_UNL: begin
          if (w_good) begin
            w_cnt_nx   = CNT_W'(1);
            w_state_nx = (LOCK_CNT <= 1) ? S_LCK : S_ACQ;
          end
        end
        S_ACQ: begin
          if (w_good) begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc >= CNT_V) w_state_nx = S_LCK;
          end else begin
            w_cnt_nx   = '0;
            w_state_nx = S_UNL;
          end
        end
        S_LCK: begin
          if (!w_good) w_state_nx = S_SLP;
        end
        S_SLP: begin
          if (w_good) begin
            w_state_nx = S_LCK;
          end else begin
            w_cnt_nx   = '0;
            w_state_nx = S_UNL;
          end
        end
        default: begin
          w_cnt_nx   = '0;
          w_state_nx = S_UNL;
        end
      endcase
    end
    if (w_sat) begin
      w_cnt_nx   = '0;
      w_state_nx = S_UNL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_ftw      <= NOM_V;
      r_clk_fb   <= 1'b0;
      r_clk_fb_d <= 1'b0;
      r_tick     <= 1'b0;
      r_sat_hi   <= 1'b0;
      r_sat_lo   <= 1'b0;
      r_state    <= S_UNL;
      r_cnt      <= '0;
      r_locked   <= 1'b0;
    end else if (ena) begin
      r_acc      <= r_acc + r_ftw;
      r_clk_fb   <= r_acc[ACC_W-1];
      r_clk_fb_d <= r_clk_fb;
      r_tick     <= r_clk_fb & ~r_clk_fb_d;
      if (w_upd) begin
        r_sat_hi <= w_over;
        r_sat_lo <= w_under;
        if (w_over)       r_ftw <= MAX_V;
        else if (w_under) r_ftw <= MIN_V;
        else              r_ftw <= w_sum[ACC_W-1:0];
      end
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_locked <= (w_state_nx == S_LCK) || (w_state_nx == S_SLP);
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign clk_fb_out = r_clk_fb;
  assign fb_tick    = r_tick;
  assign ftw        = r_ftw;
  assign sat_hi     = r_sat_hi;
  assign sat_lo     = r_sat_lo;
  assign locked     = r_locked;

endmodule

// File: tb/tb_ddmtd_nco.sv
// Directed bench for ddmtd_nco at default parameters.
// Inputs change and outputs are sampled on the falling edge.
module tb_ddmtd_nco;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        ctrl_valid;
  logic [23:0] ctrl;
  logic        phase_valid;
  logic [17:0] phase_err;
  logic        clk_fb_out;
  logic        fb_tick;
  logic [23:0] ftw;
  logic        sat_hi;
  logic        sat_lo;
  logic        locked;

  int n_chk = 0;
  int n_err = 0;

  ddmtd_nco dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .ctrl_valid  (ctrl_valid),
    .ctrl        (ctrl),
    .phase_valid (phase_valid),
    .phase_err   (phase_err),
    .clk_fb_out  (clk_fb_out),
    .fb_tick     (fb_tick),
    .ftw         (ftw),
    .sat_hi      (sat_hi),
    .sat_lo      (sat_lo),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic set_ctrl(input logic [23:0] v);
    ctrl       = v;
    ctrl_valid = 1'b1;
    tick(1);
    ctrl_valid = 1'b0;
  endtask

  task automatic pstb(input logic [17:0] e);
    phase_err   = e;
    phase_valid = 1'b1;
    tick(1);
    phase_valid = 1'b0;
  endtask

  task automatic lock16();
    for (int i = 0; i < 16; i++) pstb(18'd10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_t;
    int second_t;
    int n_t;
    int high;
    rst = 1'b1; ena = 1'b1; ctrl_valid = 1'b0; ctrl = '0;
    phase_valid = 1'b0; phase_err = '0;
    @(negedge clk);
    tick(2);
    chk("rst_ftw", ftw, 65536);
    chk("rst_clk_fb", clk_fb_out, 0);
    chk("rst_tick", fb_tick, 0);
    chk("rst_sat_hi", sat_hi, 0);
    chk("rst_sat_lo", sat_lo, 0);
    chk("rst_locked", locked, 0);
    rst = 1'b0;

    // free run: ticks at 130 and 386, 128 high cycles per period
    first_t = 0; second_t = 0; n_t = 0; high = 0;
    for (int e = 1; e <= 400; e++) begin
      tick(1);
      if (fb_tick) begin
        n_t++;
        if (first_t == 0) first_t = e;
        else if (second_t == 0) second_t = e;
      end
      if (e >= 130 && e <= 385 && clk_fb_out) high++;
    end
    chk("first_tick", first_t, 130);
    chk("second_tick", second_t, 386);
    chk("tick_count", n_t, 2);
    chk("high_cycles", high, 128);

    set_ctrl(24'h001000);
    chk("upd_ftw", ftw, 65552);
    chk("upd_sat_hi", sat_hi, 0);
    chk("upd_sat_lo", sat_lo, 0);

    // strobe at edge 128: old ftw must still be added there
    do_reset();
    tick(127);
    set_ctrl(24'hC00000);
    chk("step_ftw", ftw, 49152);
    chk("step_sat_lo", sat_lo, 0);
    chk("step_fb128", clk_fb_out, 0);
    tick(1);
    chk("step_fb129", clk_fb_out, 1);

    set_ctrl(24'h7FFFFF);
    chk("hi_ftw", ftw, 81920);
    chk("hi_sat_hi", sat_hi, 1);
    chk("hi_sat_lo", sat_lo, 0);
    set_ctrl(24'h800000);
    chk("lo_ftw", ftw, 49152);
    chk("lo_sat_hi", sat_hi, 0);
    chk("lo_sat_lo", sat_lo, 1);
    set_ctrl(24'h000000);
    chk("nom_ftw", ftw, 65536);
    chk("nom_sat_lo", sat_lo, 0);

    lock16();
    chk("pre_hi_lock", locked, 1);
    set_ctrl(24'h7FFFFF);
    chk("hi_unlock", locked, 0);
    lock16();
    chk("pre_lo_lock", locked, 1);
    set_ctrl(24'h800000);
    chk("lo_unlock", locked, 0);
    lock16();
    chk("pre_same_lock", locked, 1);
    ctrl = 24'h7FFFFF; ctrl_valid = 1'b1;
    phase_err = 18'd10; phase_valid = 1'b1;
    tick(1);
    ctrl_valid = 1'b0; phase_valid = 1'b0;
    chk("same_unlock", locked, 0);
    for (int i = 0; i < 15; i++) pstb(18'd10);
    chk("same_cnt_clr", locked, 0);
    pstb(18'd10);
    chk("same_relock", locked, 1);

    // lock FSM
    do_reset();
    for (int i = 0; i < 16; i++) begin
      pstb(18'd10);
      if (i == 14) chk("lock_15", locked, 0);
    end
    chk("lock_16", locked, 1);
    pstb(18'h3FF38);
    chk("slip_m200", locked, 1);
    pstb(18'd5);
    chk("relock_p5", locked, 1);
    pstb(18'd65);
    chk("slip_p65", locked, 1);
    pstb(18'd65);
    chk("unlock_p65", locked, 0);
    pstb(18'h20000);
    chk("mneg_unl", locked, 0);
    for (int i = 0; i < 10; i++) pstb((i % 2 == 0) ? 18'd64 : 18'h3FFC0);
    pstb(18'h20000);
    for (int i = 0; i < 15; i++) pstb(18'd64);
    chk("mneg_acq", locked, 0);
    pstb(18'h3FFC0);
    chk("tol_lock", locked, 1);
    pstb(18'h20000);
    chk("mneg_lck", locked, 1);
    pstb(18'h20000);
    chk("mneg_slp", locked, 0);

    // freeze at enabled edge 200 with clk_fb high
    do_reset();
    lock16();
    chk("frz_lock", locked, 1);
    tick(184);
    chk("frz_fb200", clk_fb_out, 1);
    ena = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      ctrl        = 24'h7FFFFF;
      phase_err   = 18'h20000;
      ctrl_valid  = (i % 2 == 0);
      phase_valid = (i % 2 == 1);
      tick(1);
      chk("frz_tick", fb_tick, 0);
      chk("frz_fb", clk_fb_out, 1);
      chk("frz_ftw", ftw, 65536);
      chk("frz_locked", locked, 1);
    end
    ctrl_valid = 1'b0; phase_valid = 1'b0;
    ena = 1'b1;
    tick(56);
    chk("res_fb256", clk_fb_out, 1);
    tick(1);
    chk("res_fb257", clk_fb_out, 0);
    tick(128);
    chk("res_tick385", fb_tick, 0);
    tick(1);
    chk("res_tick386", fb_tick, 1);

    // mid-run reset while locked and saturated, with ena low
    set_ctrl(24'h7FFFFF);
    chk("mr_ftw", ftw, 81920);
    chk("mr_sat_hi", sat_hi, 1);
    lock16();
    chk("mr_locked", locked, 1);
    ena = 1'b0;
    do_reset();
    ena = 1'b1;
    chk("mr_rst_ftw", ftw, 65536);
    chk("mr_rst_sat_hi", sat_hi, 0);
    chk("mr_rst_sat_lo", sat_lo, 0);
    chk("mr_rst_locked", locked, 0);
    chk("mr_rst_fb", clk_fb_out, 0);
    chk("mr_rst_tick", fb_tick, 0);
    for (int i = 0; i < 15; i++) pstb(18'd10);
    chk("mr_cnt_15", locked, 0);
    pstb(18'd10);
    chk("mr_cnt_16", locked, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
